// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU arbiter.
//               - OP_ADD/OP_SUB/OP_AND/OP_OR : 2-bit opcodes seen by the ALU
//               - ALU_LATENCY                : ALU result latency in cycles
//               - state_t                    : arbiter FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   // The ALU registers its result once; EXEC covers exactly this latency.
   localparam int ALU_LATENCY = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant logic (purely combinational).
// Ports       : req_i  [1:0] - request lines
//               last_i       - index of the requester granted last
//               gnt_o  [1:0] - one-hot grant (all-zero when nothing requests)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         // Contention: whoever was served last yields.
         2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Arbitrates two requesters onto one shared, registered ALU and
//               returns each result through a valid/ready response port.
//               FSM: IDLE (accept) -> EXEC -> CAPT -> RESP -> IDLE.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               req_valid/req_ready [1:0]       - per-requester handshake
//               req_op/req_a/req_b  [1:0][..]   - per-requester operands
//               alu_op/alu_a/alu_b              - registered ALU inputs
//               alu_y/alu_carry                 - ALU result (1-cycle latency)
//               rsp_valid/rsp_ready             - response handshake
//               rsp_y/rsp_carry/rsp_id          - response payload
//               grant_cnt0/grant_cnt1           - saturating accept counters
// Config      : ALU_ARB_STATS_EN - when defined, adds grant_cnt0/grant_cnt1
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0][1:0] req_op,
   input  logic [1:0][3:0] req_a,
   input  logic [1:0][3:0] req_b,
   output logic [1:0]      alu_op,
   output logic [3:0]      alu_a,
   output logic [3:0]      alu_b,
   input  logic [3:0]      alu_y,
   input  logic            alu_carry,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [3:0]      rsp_y,
   output logic            rsp_carry,
   output logic            rsp_id
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [7:0]      grant_cnt0,
   output logic [7:0]      grant_cnt1
`endif
);

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic [1:0] alu_op_q, alu_op_d;
   logic [3:0] alu_a_q, alu_a_d;
   logic [3:0] alu_b_q, alu_b_d;
   logic [3:0] rsp_y_q, rsp_y_d;
   logic       rsp_carry_q, rsp_carry_d;
   logic       rsp_id_q, rsp_id_d;
   logic       rsp_valid_q, rsp_valid_d;

   logic [1:0] w_gnt;
   logic       w_accept;
   logic       w_acc_id;

   // last_q resets to 1 so that requester 0 holds priority after reset.
   rr_arb2 u_rr_arb2 (
      .req_i  (req_valid),
      .last_i (last_q),
      .gnt_o  (w_gnt)
   );

   assign req_ready = (state_q == IDLE) ? w_gnt : 2'b00;
   assign w_accept  = |(req_valid & req_ready);
   assign w_acc_id  = req_ready[1];

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      rsp_y_d     = rsp_y_q;
      rsp_carry_d = rsp_carry_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (w_accept) begin
               alu_op_d = req_op[w_acc_id];
               alu_a_d  = req_a[w_acc_id];
               alu_b_d  = req_b[w_acc_id];
               rsp_id_d = w_acc_id;
               last_d   = w_acc_id;
               state_d  = EXEC;
            end
         end
         // ALU samples alu_* at the end of EXEC; its result is visible in CAPT.
         EXEC: state_d = CAPT;
         CAPT: begin
            rsp_y_d     = alu_y;
            rsp_carry_d = alu_carry;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         alu_op_q    <= 2'b00;
         alu_a_q     <= 4'd0;
         alu_b_q     <= 4'd0;
         rsp_y_q     <= 4'd0;
         rsp_carry_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         rsp_y_q     <= rsp_y_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_valid = rsp_valid_q;

`ifdef ALU_ARB_STATS_EN
   logic [7:0] cnt0_q;
   logic [7:0] cnt1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= 8'd0;
         cnt1_q <= 8'd0;
      end else if (w_accept) begin
         if (!w_acc_id && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
         if ( w_acc_id && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Contains a registered
//               ALU model (SUB carry = borrow), a vector table for single
//               operations and hand-written multi-cycle sequences. Expected
//               responses are queued when stimulus is driven and compared
//               when a response handshake completes.
// Config      : ALU_ARB_STATS_EN - also exercises grant_cnt0/grant_cnt1
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
   import alu_pkg::*;

   logic            clk;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [1:0][1:0] req_op;
   logic [1:0][3:0] req_a;
   logic [1:0][3:0] req_b;
   logic [1:0]      alu_op;
   logic [3:0]      alu_a;
   logic [3:0]      alu_b;
   logic [3:0]      alu_y;
   logic            alu_carry;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [3:0]      rsp_y;
   logic            rsp_carry;
   logic            rsp_id;
`ifdef ALU_ARB_STATS_EN
   logic [7:0]      grant_cnt0;
   logic [7:0]      grant_cnt1;
`endif

   alu_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_y     (alu_y),
      .alu_carry (alu_carry),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_carry (rsp_carry),
      .rsp_id    (rsp_id)
`ifdef ALU_ARB_STATS_EN
      ,
      .grant_cnt0(grant_cnt0),
      .grant_cnt1(grant_cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared ALU model (registered, 1-cycle latency) -------
   function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_AND:  return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   always @(posedge clk) {alu_carry, alu_y} <= alu_f(alu_op, alu_a, alu_b);

   // ---------------- bookkeeping ------------------------------------------
   typedef struct packed {
      logic [3:0] y;
      logic       c;
      logic       id;
   } rsp_t;

   typedef struct {
      int         id;
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] y;
      logic       c;
   } vec_t;

   rsp_t exp_q[$];
   int   rsp_cycles[$];
   rsp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   acc_cnt  = 0;

   function automatic rsp_t mk(input logic [3:0] y, input logic c, input logic id);
      rsp_t r;
      r.y  = y;
      r.c  = c;
      r.id = id;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor / scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if ((req_valid & req_ready) != 2'b00) acc_cnt++;
         if (rsp_valid && rsp_ready) begin
            rsp_cycles.push_back(cyc);
            check("rsp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check("rsp_y_c_id", {rsp_y, rsp_carry, rsp_id}, mon_e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helper tasks ------------------------------------------
   task automatic wait_ready(input int id);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!req_ready[id] && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("ready_in_time", waited < 20, 1);
   endtask

   task automatic do_op(input vec_t v);
      int k;
      int waited;
      @(posedge clk); #1;
      req_op[v.id] = v.op;
      req_a[v.id]  = v.a;
      req_b[v.id]  = v.b;
      req_valid[v.id] = 1'b1;
      exp_q.push_back(mk(v.y, v.c, v.id[0]));
      wait_ready(v.id);
      k = cyc;
      @(posedge clk); #1;
      req_valid[v.id] = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!rsp_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("latency", cyc - k, 3);
   endtask

   vec_t vecs[8];
   int   a0;
   int   waited;
   int   n_hi;

   initial begin
      vecs[0] = '{0, OP_ADD, 4'd8,  4'd6,  4'd14, 1'b0};
      vecs[1] = '{1, OP_ADD, 4'd9,  4'd8,  4'd1,  1'b1};
      vecs[2] = '{1, OP_SUB, 4'd8,  4'd6,  4'd2,  1'b0};
      vecs[3] = '{1, OP_AND, 4'd8,  4'd6,  4'd0,  1'b0};
      vecs[4] = '{1, OP_OR,  4'd8,  4'd6,  4'd14, 1'b0};
      vecs[5] = '{0, OP_SUB, 4'd3,  4'd5,  4'd14, 1'b1};
      vecs[6] = '{0, OP_ADD, 4'd15, 4'd15, 4'd14, 1'b1};
      vecs[7] = '{1, OP_OR,  4'd0,  4'd0,  4'd0,  1'b0};

      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // Reset state.
      #12;
      check("rst_alu_op",    alu_op,    0);
      check("rst_alu_a",     alu_a,     0);
      check("rst_alu_b",     alu_b,     0);
      check("rst_rsp_y",     rsp_y,     0);
      check("rst_rsp_carry", rsp_carry, 0);
      check("rst_rsp_id",    rsp_id,    0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
`ifdef ALU_ARB_STATS_EN
      check("rst_cnt0", grant_cnt0, 0);
      check("rst_cnt1", grant_cnt1, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Single operations.
      for (int i = 0; i < 8; i++) do_op(vecs[i]);

      // Response back-pressure: payload held, nobody accepted meanwhile.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_op[0] = OP_AND; req_a[0] = 4'd12; req_b[0] = 4'd10;
      req_valid[0] = 1'b1;
      exp_q.push_back(mk(4'd8, 1'b0, 1'b0));
      wait_ready(0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!rsp_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("hold_rsp_arrived", rsp_valid, 1);
      @(posedge clk); #1;
      req_op[1] = OP_OR; req_a[1] = 4'd1; req_b[1] = 4'd2;
      req_valid[1] = 1'b1;
      a0 = acc_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_y",     rsp_y,     8);
         check("hold_id",    rsp_id,    0);
         check("hold_ready", req_ready, 0);
      end
      // Requester 1 withdraws before it could be accepted: never served.
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      rsp_ready    = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      check("hold_no_accept", acc_cnt - a0, 0);
      check("hold_drained",   exp_q.size(), 0);

      // Reset during EXEC: everything clears, no response follows.
      @(posedge clk); #1;
      req_op[0] = OP_ADD; req_a[0] = 4'd9; req_b[0] = 4'd5;
      req_valid[0] = 1'b1;
      wait_ready(0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      req_valid[0] = 1'b0;
      #1;
      check("mid_rst_alu_op",    alu_op,    0);
      check("mid_rst_alu_a",     alu_a,     0);
      check("mid_rst_alu_b",     alu_b,     0);
      check("mid_rst_rsp_y",     rsp_y,     0);
      check("mid_rst_rsp_carry", rsp_carry, 0);
      check("mid_rst_rsp_id",    rsp_id,    0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_req_ready", req_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_hi = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) n_hi++;
      end
      check("no_rsp_after_reset", n_hi, 0);

      // Round robin with both requesters always valid.
      @(posedge clk); #1;
      req_op[0] = OP_ADD; req_a[0] = 4'd1; req_b[0] = 4'd2;
      req_op[1] = OP_ADD; req_a[1] = 4'd4; req_b[1] = 4'd5;
      for (int i = 0; i < 4; i++)
         exp_q.push_back((i % 2 == 0) ? mk(4'd3, 1'b0, 1'b0) : mk(4'd9, 1'b0, 1'b1));
      rsp_cycles.delete();
      a0 = acc_cnt;
      req_valid = 2'b11;
      waited = 0;
      while ((acc_cnt - a0) < 4 && waited < 100) begin
         @(negedge clk); #1;
         waited++;
      end
      check("rr_accepts", acc_cnt - a0, 4);
      @(posedge clk); #1;
      req_valid = 2'b00;
      waited = 0;
      while (rsp_cycles.size() < 4 && waited < 40) begin
         @(negedge clk); #1;
         waited++;
      end
      check("rr_rsp_count", rsp_cycles.size(), 4);
      for (int i = 1; i < 4; i++)
         check("rr_spacing", rsp_cycles[i] - rsp_cycles[i-1], 4);

`ifdef ALU_ARB_STATS_EN
      // Counters saturate at 255.
      check("cnt0_pre", grant_cnt0, 2);
      check("cnt1_pre", grant_cnt1, 2);
      @(posedge clk); #1;
      req_op[0] = OP_ADD; req_a[0] = 4'd1; req_b[0] = 4'd1;
      for (int i = 0; i < 300; i++) exp_q.push_back(mk(4'd2, 1'b0, 1'b0));
      a0 = acc_cnt;
      req_valid[0] = 1'b1;
      waited = 0;
      while ((acc_cnt - a0) < 300 && waited < 2000) begin
         @(negedge clk); #1;
         waited++;
      end
      check("stats_accepts", acc_cnt - a0, 300);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      waited = 0;
      while (exp_q.size() > 0 && waited < 40) begin
         @(negedge clk); #1;
         waited++;
      end
      check("cnt0_sat", grant_cnt0, 255);
      check("cnt1_post", grant_cnt1, 2);
`endif

      repeat (4) @(negedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports req_valid[i]  input  1 and req_ready[i]  output  1, for i = 0,1, as a per-requester handshake.
REQ-004 SHALL have ports req_op[i]  input  2 (00 ADD, 01 SUB, 10 AND, 11 OR), req_a[i]  input  4 and req_b[i]  input  4.
REQ-005 SHALL have ports alu_op  output  2, alu_a  output  4 and alu_b  output  4, all registered and driving the shared ALU.
REQ-006 SHALL have ports alu_y  input  4 and alu_carry  input  1, taken from the ALU's registered outputs with 1-cycle latency.
REQ-007 SHALL have ports rsp_valid  output  1 and rsp_ready  input  1 as the response handshake.
REQ-008 SHALL have ports rsp_y  output  4, rsp_carry  output  1 and rsp_id  output  1 (index of the requester being answered).

Function
REQ-009 SHALL implement FSM states IDLE, EXEC, CAPT and RESP.
REQ-010 In IDLE, req_ready SHALL be high only for the granted requester; all other ready outputs SHALL be 0.
REQ-011 A transfer SHALL occur when valid and ready are both high; on a transfer, the block SHALL latch op/a/b into alu_op/alu_a/alu_b, latch the id, and move to EXEC.
REQ-012 EXEC SHALL last exactly 1 cycle, then move to CAPT.
REQ-013 In CAPT, the block SHALL register alu_y and alu_carry into rsp_y and rsp_carry unchanged, then move to RESP.
REQ-014 In RESP, rsp_valid SHALL be 1 and all response outputs SHALL be held stable until rsp_ready=1, then the FSM SHALL return to IDLE.
REQ-015 Latency SHALL be exactly 3 cycles from the accept edge to first rsp_valid high; back-to-back throughput SHALL be 1 op per 4 cycles when rsp_ready is held high.
REQ-016 Arbitration SHALL be 2-way round-robin: with both requesters valid, the last-served requester loses; the priority pointer SHALL update only on an accept.
REQ-017 When only one requester is valid, it SHALL be granted regardless of the priority pointer.
REQ-018 req_ready SHALL be 0 in EXEC, CAPT and RESP; requests arriving then SHALL wait and not be dropped.
REQ-019 A requester deasserting valid before its accept SHALL NOT be served.

Reset
REQ-020 rst_n=0 SHALL force: FSM to IDLE, priority pointer to requester 0, and alu_op, alu_a, alu_b, rsp_y, rsp_carry, rsp_id and rsp_valid to 0, all asynchronously.
REQ-021 Reset asserted mid-operation SHALL abort the in-flight operation with no response issued; the first grant after reset SHALL go to requester 0.

Configuration
REQ-022 When macro ALU_ARB_STATS_EN is defined, the block SHALL add outputs grant_cnt0 and grant_cnt1 (8-bit each), counting accepts per requester, saturating at 255, and cleared by reset.
REQ-023 When ALU_ARB_STATS_EN is undefined, those ports and counters SHALL be absent, with behaviour otherwise identical.

Structure
REQ-024 Package alu_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_AND, OP_OR), the FSM state typedef and the ALU latency constant (1).
REQ-025 The round-robin grant logic SHALL be a separate sub-module, rr_arb2, taking req[1:0] and the last-grant pointer and producing a one-hot grant.

Verification
REQ-026 Requester 0 sends ADD a=8 b=6 -> 3 cycles later rsp_valid=1, rsp_y=14, rsp_carry=0, rsp_id=0.
REQ-027 Requester 1 sends ADD a=9 b=8 -> rsp_y=1, rsp_carry=1, rsp_id=1.
REQ-028 Requester 1 sends SUB, AND and OR with a=8 b=6 -> rsp_y=2, 0 and 14 respectively.
REQ-029 Both requesters hold valid continuously, with rsp_ready high, for 4 ops -> rsp_id sequence is 0,1,0,1 and the spacing between responses is 4 cycles.
REQ-030 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_y and rsp_id are held stable, both req_ready are 0, and no new accept occurs.
REQ-031 rst_n pulsed low during EXEC -> all outputs go to 0 immediately and no rsp_valid follows; with ALU_ARB_STATS_EN defined, 300 accepts from requester 0 -> grant_cnt0=255.
